// File: rtl/vector_pattern_seq.sv
// Vector pattern sequencer: plays back a loadable vertex list as jump/draw commands to the line drawer.
// Latency: start sampled at edge k -> first jump pulse after edge k+2; then one command every 2 cycles at best.
// Backpressure: holds in ISSUE while ready is low, with no timeout; stop takes effect at the end of the current frame.
// Optional macro PATSEQ_FRAME_CNT_EN adds a 16-bit wrapping frame_cnt output.
module vector_pattern_seq #(
  parameter int COORD_W = 12,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_jump,
  input  logic               start,
  input  logic               stop,
  input  logic               loop,
  input  logic [AW:0]        len,
  input  logic [COORD_W-1:0] x_off,
  input  logic [COORD_W-1:0] y_off,
  input  logic               ready,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               draw,
  output logic               jump,
  output logic               busy,
  output logic               done
`ifdef PATSEQ_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int ENT_W = 2 * COORD_W + 1;
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t             state;
  state_t             state_nx;
  logic [AW-1:0]      index;
  logic [AW:0]        eff_len;
  logic               stop_req;

  // Entry layout: {jump flag, x, y}
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [ENT_W-1:0]   rd_q;

  logic               start_ok;
  logic               issue;
  logic               last;
  logic               frame_end;
  logic               finish;
  logic [COORD_W-1:0] sat_x;
  logic [COORD_W-1:0] sat_y;

  // Add with clamp to full scale so offset patterns pin to the screen edge instead of wrapping.
  function automatic logic [COORD_W-1:0] sat_add(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    logic [COORD_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[COORD_W] ? {COORD_W{1'b1}} : s[COORD_W-1:0];
  endfunction

  assign busy = (state != IDLE);

  // Entry RAM: write any time; read latched only in FETCH so a stalled ISSUE keeps its entry stable.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= {wr_jump, wr_x, wr_y};
    if (state == FETCH)
      rd_q <= mem[index];
  end

  // Next-state and per-cycle decisions for the playback walk.
  always_comb begin
    state_nx  = state;
    start_ok  = (state == IDLE) && start && (len != '0);
    issue     = (state == ISSUE) && ready;
    last      = ({1'b0, index} == (eff_len - LEN_ONE));
    frame_end = issue && last;
    finish    = frame_end && !(loop && !(stop_req || stop));
    sat_x     = sat_add(rd_q[2*COORD_W-1:COORD_W], x_off);
    sat_y     = sat_add(rd_q[COORD_W-1:0], y_off);
    case (state)
      IDLE:    if (start_ok) state_nx = FETCH;
      FETCH:   state_nx = ISSUE;
      ISSUE:   if (issue) state_nx = finish ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Index, frame length, stop request and registered command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= '0;
      eff_len  <= '0;
      stop_req <= 1'b0;
      x        <= '0;
      y        <= '0;
      draw     <= 1'b0;
      jump     <= 1'b0;
      done     <= 1'b0;
    end else begin
      draw <= 1'b0;
      jump <= 1'b0;
      done <= 1'b0;
      if (start_ok) begin
        index   <= '0;
        eff_len <= (len > DEPTH_L) ? DEPTH_L : len;
      end
      if (state != IDLE)
        stop_req <= stop_req | stop;
      if (issue) begin
        x <= sat_x;
        y <= sat_y;
        // The first vertex of every frame is a move, whatever its stored flag says.
        if ((index == '0) || rd_q[ENT_W-1])
          jump <= 1'b1;
        else
          draw <= 1'b1;
        if (last) begin
          index <= '0;
          if (finish) begin
            done     <= 1'b1;
            stop_req <= 1'b0;
          end
        end else begin
          index <= index + IDX_ONE;
        end
      end
    end
  end

`ifdef PATSEQ_FRAME_CNT_EN
  // Counts completed frames, looped or final; survives start, wraps at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      frame_cnt <= '0;
    else if (frame_end)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vector_pattern_seq.sv
// Bench for vector_pattern_seq: directed scenarios plus a command-list model checked every cycle.
// Inputs are driven 1ns after the rising edge; the checker samples on the falling edge.
// Set PATSEQ_FRAME_CNT_EN to also check frame_cnt.
module tb_vector_pattern_seq;

  localparam int CW   = 12;
  localparam int DEP  = 16;
  localparam int AWB  = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            wr_en;
  logic [AWB-1:0]  wr_addr;
  logic [CW-1:0]   wr_x, wr_y;
  logic            wr_jump, start, stop, loop;
  logic [AWB:0]    len;
  logic [CW-1:0]   x_off, y_off;
  logic            ready;
  logic [CW-1:0]   x, y;
  logic            draw, jump, busy, done;
`ifdef PATSEQ_FRAME_CNT_EN
  logic [15:0]     frame_cnt;
`endif

  vector_pattern_seq #(.COORD_W(CW), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x(wr_x),
    .wr_y(wr_y), .wr_jump(wr_jump), .start(start), .stop(stop), .loop(loop),
    .len(len), .x_off(x_off), .y_off(y_off), .ready(ready), .x(x), .y(y),
    .draw(draw), .jump(jump), .busy(busy), .done(done)
`ifdef PATSEQ_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int j;
  } cmd_t;

  cmd_t exp_q[$];
  int   mx [DEP];
  int   my [DEP];
  int   mj [DEP];

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cmds = 0;
  int n_jump = 0;
  int n_draw = 0;
  int fc_exp = 0;
  int cyc    = 0;
  int last_cmd = -10;
  int hold_x = 0;
  int hold_y = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int sat(input int a, input int b);
    return (a + b > MAXC) ? MAXC : a + b;
  endfunction

  // Expected command list for one frame, straight from the playback rules.
  task automatic push_frame(input int l, input int xo, input int yo);
    cmd_t c;
    int n;
    n = (l > DEP) ? DEP : l;
    for (int i = 0; i < n; i++) begin
      c.x = sat(mx[i], xo);
      c.y = sat(my[i], yo);
      c.j = (i == 0) ? 1 : mj[i];
      exp_q.push_back(c);
    end
  endtask

  // Every-cycle checker: each pulse must match the next expected command, otherwise x/y must hold.
  always @(negedge clk) begin
    cmd_t e;
    cyc++;
    if (reset) begin
      hold_x   = 0;
      hold_y   = 0;
      last_cmd = -10;
    end else if (draw || jump) begin
      n_cmds++;
      if (jump) n_jump++;
      if (draw) n_draw++;
      chk("one_hot", int'(draw && jump), 0);
      chk("spacing", int'(cyc - last_cmd >= 2), 1);
      last_cmd = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", 1, 0);
        hold_x = int'(x);
        hold_y = int'(y);
      end else begin
        e = exp_q.pop_front();
        chk("cmd_x", int'(x), e.x);
        chk("cmd_y", int'(y), e.y);
        chk("cmd_jump", int'(jump), e.j);
        hold_x = e.x;
        hold_y = e.y;
      end
    end else begin
      chk("hold_x", int'(x), hold_x);
      chk("hold_y", int'(y), hold_y);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input int ex, input int ey, input int ej);
    step();
    wr_en   = 1'b1;
    wr_addr = AWB'(a);
    wr_x    = CW'(ex);
    wr_y    = CW'(ey);
    wr_jump = ej[0];
    step();
    wr_en = 1'b0;
    mx[a] = ex;
    my[a] = ey;
    mj[a] = ej;
  endtask

  task automatic start_play(input int l);
    step();
    len   = (AWB+1)'(l);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_fc();
`ifdef PATSEQ_FRAME_CNT_EN
    chk("frame_cnt", int'(frame_cnt), fc_exp);
`endif
  endtask

  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 300; k++) begin
      step();
      if (done) break;
    end
    if (k == 300) begin
      chk({nm, "_done_timeout"}, 0, 1);
    end else begin
      chk({nm, "_busy_low"}, int'(busy), 0);
      @(negedge clk);
      #1;
      chk({nm, "_queue_empty"}, exp_q.size(), 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, j0, d0, cnt, quiet, k;
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_x = '0; wr_y = '0; wr_jump = 1'b0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
    x_off = '0; y_off = '0; ready = 1'b1;
    step(); step();
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_pulses", int'({draw, jump, done}), 0);
    chk("rst_busy", int'(busy), 0);
    check_fc();
    reset = 1'b0;

    // Square, one-shot, with first-command latency pinned.
    write_entry(0, 30, 3, 1);
    write_entry(1, 0, 27, 0);
    write_entry(2, 30, 30, 0);
    write_entry(3, 0, 0, 0);
    push_frame(4, 0, 0);
    start_play(4);
    chk("sq_busy", int'(busy), 1);
    step();
    chk("sq_lat_k1_idle", int'(jump || draw), 0);
    step();
    chk("sq_lat_k2_jump", int'(jump), 1);
    chk("sq_first_x", int'(x), 30);
    chk("sq_first_y", int'(y), 3);
    wait_done("square");
    chk("sq_last_x", int'(x), 0);
    chk("sq_last_y", int'(y), 0);
    fc_exp = 1;
    check_fc();

    // Offset saturation on x, plain add on y.
    write_entry(0, 200, 10, 1);
    x_off = 12'd4000;
    y_off = 12'd5;
    push_frame(1, 4000, 5);
    start_play(1);
    wait_done("sat");
    chk("sat_x", int'(x), 4095);
    chk("sat_y", int'(y), 15);
    x_off = '0;
    y_off = '0;
    fc_exp = 2;

    // Entry 0 stored as draw still comes out as a jump.
    write_entry(0, 5, 6, 0);
    j0 = n_jump;
    d0 = n_draw;
    push_frame(1, 0, 0);
    start_play(1);
    wait_done("force_jump");
    chk("force_jump_jumps", n_jump - j0, 1);
    chk("force_jump_draws", n_draw - d0, 0);
    fc_exp = 3;
    check_fc();

    // Loop with stop in the middle of frame 2: exactly two frames.
    write_entry(0, 1, 2, 0);
    write_entry(1, 3, 4, 1);
    write_entry(2, 5, 6, 0);
    loop = 1'b1;
    push_frame(3, 0, 0);
    push_frame(3, 0, 0);
    c0 = n_cmds;
    start_play(3);
    cnt = 0;
    for (k = 0; k < 100 && cnt < 4; k++) begin
      step();
      if (jump || draw) cnt++;
    end
    chk("loop_reached_4", cnt, 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_done("loop_stop");
    chk("loop_cmd_count", n_cmds - c0, 6);
    loop = 1'b0;
    fc_exp = 5;
    check_fc();

    // Ready stall: nothing moves until ready returns.
    ready = 1'b0;
    push_frame(3, 0, 0);
    start_play(3);
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (jump || draw || x != 12'd5 || y != 12'd6) quiet = 0;
    end
    chk("stall_quiet", quiet, 1);
    chk("stall_busy", int'(busy), 1);
    ready = 1'b1;
    step();
    chk("stall_release_jump", int'(jump), 1);
    chk("stall_release_x", int'(x), 1);
    chk("stall_release_y", int'(y), 2);
    wait_done("stall");
    fc_exp = 6;

    // Reset right after the 2nd command, then replay from entry 0.
    push_frame(3, 0, 0);
    start_play(3);
    cnt = 0;
    for (k = 0; k < 100 && cnt < 2; k++) begin
      step();
      if (jump || draw) cnt++;
    end
    chk("rst_mid_reached_2", cnt, 2);
    reset = 1'b1;
    #1;
    exp_q.delete();
    chk("rst_mid_x", int'(x), 0);
    chk("rst_mid_y", int'(y), 0);
    chk("rst_mid_pulses", int'({draw, jump, done}), 0);
    chk("rst_mid_busy", int'(busy), 0);
    fc_exp = 0;
    check_fc();
    step();
    reset = 1'b0;
    push_frame(3, 0, 0);
    start_play(3);
    step();
    step();
    chk("replay_first_jump", int'(jump), 1);
    chk("replay_first_x", int'(x), 1);
    wait_done("replay");
    fc_exp = 1;
    check_fc();

    // start with len = 0 is ignored.
    c0 = n_cmds;
    start_play(0);
    quiet = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (busy || done) quiet = 0;
    end
    chk("len0_quiet", quiet, 1);
    chk("len0_no_cmds", n_cmds - c0, 0);
    check_fc();

    step();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
